rsa_job_ctrl: RTL and testbench
===============================

# rsa_job_ctrl

Job sequencer for the RSA datapath. It sits between the serial-to-parallel loader, the `mon_exp` engine and the parallel-to-serial sender. It turns a "operands loaded" pulse into exactly one engine start and captures the engine result. It hands the result to the sender, then holds off new jobs until every result byte has left the UART. A watchdog traps hung jobs, and the block reports busy, error, dropped-job and cycle-count status.

## Interface
- `BITLEN`, 64, operand/result width in bits; must be a multiple of 8.
- `CNTW`, 24, width of the cycle counter and watchdog.
- `TIMEOUT`, 24'hFFFFFF, watchdog limit in cycles (RUN plus DRAIN); must fit in CNTW.

Ports:
- `clk`  in  1  system clock; the block uses one clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  one-cycle pulse from the loader: operands and exponent are in BRAM.
- `rx_enable`  out  1  high when the loader may accept UART bytes (IDLE only).
- `exp_start`  out  1  one-cycle start pulse to `mon_exp`.
- `exp_stop`  in  1  `mon_exp` done pulse.
- `exp_ans`  in  BITLEN  `mon_exp` result, valid while `exp_stop` is high.
- `res_valid`  out  1  one-cycle pulse to the sender.
- `res_data`  out  BITLEN  latched result.
- `tx_busy`  in  1  UART `is_transmitting`.
- `clr_err`  in  1  leave the ERR state.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  watchdog fired; sticky.
- `dropped`  out  8  saturating count of `load_valid` pulses ignored while busy.
- `last_cycles`  out  CNTW  cycles from `exp_start` to `exp_stop` for the last completed job.

## Operation
- States: IDLE, START, RUN, SEND, DRAIN, ERR. Reset enters IDLE.
- IDLE:
  - `rx_enable` is 1.
  - `load_valid` moves to START.
- START:
  - `exp_start` is 1 for this single cycle.
  - Clear `cyc` to 0.
  - Go to RUN.
- RUN:
  - Increment `cyc` each cycle.
  - `exp_stop` latches `exp_ans` into `res_data`, latches `cyc` into `last_cycles`, and moves to SEND.
  - If `cyc` reaches TIMEOUT, move to ERR.
- SEND:
  - `res_valid` is 1 for this single cycle.
  - Clear `nbytes` to 0.
  - Go to DRAIN.
- DRAIN:
  - `cyc` keeps counting.
  - Each falling edge of `tx_busy` (registered previous 1, current 0) increments `nbytes`.
  - When `nbytes` reaches BITLEN/8, go to IDLE.
  - If `cyc` reaches TIMEOUT, go to ERR.
  - A `tx_busy` that is low for many cycles before the first rise is legal.
- ERR:
  - `err` is 1; `busy` is 1.
  - `clr_err` moves to IDLE and clears `err`.
  - `res_data` and `last_cycles` are kept.
- `load_valid` in any state other than IDLE is ignored and increments `dropped`. `dropped` saturates at 255 and clears only on `rst`.
- `exp_stop` outside RUN is ignored; `res_data` is unchanged.
- `clr_err` outside ERR is ignored.

Simultaneous events:
- `exp_stop` and the timeout in the same cycle: stop wins, and the job completes normally.
- In RUN, `load_valid` and `exp_stop` in the same cycle: stop is taken, and the load counts as dropped.
- In DRAIN, the final falling edge and the timeout in the same cycle: the transition is to IDLE.

Reset mid-job: the block returns to IDLE on the next edge and all registers take their reset values. An in-flight `mon_exp` result arriving after reset is ignored.

## Timing
- All outputs are registered. Reset values:
  - `rx_enable` = 1
  - `exp_start` = 0, `res_valid` = 0, `busy` = 0, `err` = 0
  - `res_data` = 0, `dropped` = 0, `last_cycles` = 0
- `load_valid` sampled at edge k: `exp_start` is high in cycle k+1, and `busy` and `rx_enable` change in the same cycle.
- `exp_stop` sampled at edge m: `res_valid` and the new `res_data` are visible in cycle m+1. `res_data` then stays stable until the next job's stop.
- `last_cycles` = number of RUN cycles before the stop, inclusive. Example: stop in the first RUN cycle gives `last_cycles` = 1.
- IDLE is re-entered the cycle after the BITLEN/8-th falling edge of `tx_busy`.
- Minimum job-to-job spacing: 4 cycles plus the engine time plus the drain time.

## Test plan
- Nominal job (BITLEN=64):
  - Stimulus: `load_valid` at cycle 10; `exp_stop` with `exp_ans`=64'h0123456789ABCDEF 50 cycles after `exp_start`; 8 `tx_busy` pulses.
  - Response: one `exp_start`; `res_data`=64'h0123456789ABCDEF; one `res_valid`; `last_cycles`=50; `busy` falls and `rx_enable` rises one cycle after the 8th falling edge.
- Drop counting:
  - Stimulus: 3 `load_valid` pulses during RUN and 2 during DRAIN.
  - Response: `dropped`=5; no extra `exp_start`. Separately, force 300 dropped loads: `dropped` holds at 255.
- Watchdog:
  - Stimulus: TIMEOUT=100, no `exp_stop`.
  - Response: ERR after 100 RUN cycles; `err`=1; a late `exp_stop` leaves `res_data` unchanged; `clr_err` returns to IDLE with `err`=0.
- Race:
  - Stimulus: `exp_stop` in the same cycle `cyc` reaches TIMEOUT.
  - Response: SEND is taken and `err` stays 0.
- Reset mid-DRAIN:
  - Stimulus: `rst` after 3 of 8 bytes.
  - Response: next cycle all outputs at reset values; a following job runs normally.
- Spurious inputs:
  - Stimulus: `exp_stop` in IDLE, `clr_err` in IDLE, `tx_busy` toggling in IDLE.
  - Response: no state change and no output pulse.

Source files
------------

// File: rtl/rsa_job_if.sv
// rsa_job_if: handshake and status bundle between the RSA job sequencer and its loader/engine/sender
interface rsa_job_if #(
  parameter int BITLEN = 64,
  parameter int CNTW = 24
);
  logic load_valid;
  logic rx_enable;
  logic exp_start;
  logic exp_stop;
  logic [BITLEN-1:0] exp_ans;
  logic res_valid;
  logic [BITLEN-1:0] res_data;
  logic tx_busy;
  logic clr_err;
  logic busy;
  logic err;
  logic [7:0] dropped;
  logic [CNTW-1:0] last_cycles;
  modport master (
    input load_valid, exp_stop, exp_ans, tx_busy, clr_err,
    output rx_enable, exp_start, res_valid, res_data, busy, err, dropped, last_cycles
  );
  modport slave (
    output load_valid, exp_stop, exp_ans, tx_busy, clr_err,
    input rx_enable, exp_start, res_valid, res_data, busy, err, dropped, last_cycles
  );
endinterface

// File: rtl/rsa_job_ctrl.sv
// rsa_job_ctrl: sequences one mon_exp job per load, hands the result to the UART sender and traps hung jobs
module rsa_job_ctrl #(
  parameter int BITLEN = 64,
  parameter int CNTW = 24,
  parameter logic [CNTW-1:0] TIMEOUT = 24'hFFFFFF
) (
  input logic clk,
  input logic rst,
  rsa_job_if.master bus
);
  localparam int NB = BITLEN / 8;
  localparam int NBW = $clog2(NB + 1);
  typedef enum logic [2:0] {IDLE, START, RUN, SEND, DRAIN, ERR} state_t;
  state_t state, nxt;
  logic [CNTW-1:0] cyc, cyc_inc;
  logic [NBW-1:0] nbytes, nb_inc;
  logic tx_prev, fall, tmo, last_byte;
  assign cyc_inc = cyc + CNTW'(1);
  assign nb_inc = nbytes + NBW'(1);
  assign tmo = cyc_inc >= TIMEOUT;
  assign fall = tx_prev & ~bus.tx_busy;
  assign last_byte = fall && nb_inc == NBW'(NB);
  // next state: stop beats timeout in RUN, final byte beats timeout in DRAIN
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.load_valid ? START : IDLE;
      START:   nxt = RUN;
      RUN:     nxt = bus.exp_stop ? SEND : tmo ? ERR : RUN;
      SEND:    nxt = DRAIN;
      DRAIN:   nxt = last_byte ? IDLE : tmo ? ERR : DRAIN;
      ERR:     nxt = bus.clr_err ? IDLE : ERR;
      default: nxt = IDLE;
    endcase
  end
  // state, counters, result capture and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc <= '0;
      nbytes <= '0;
      tx_prev <= 1'b0;
      bus.rx_enable <= 1'b1;
      bus.exp_start <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
      bus.res_data <= '0;
      bus.dropped <= '0;
      bus.last_cycles <= '0;
    end else begin
      state <= nxt;
      tx_prev <= bus.tx_busy;
      cyc <= (state == START) ? '0 : (state == RUN || state == DRAIN) ? cyc_inc : cyc;
      nbytes <= (state == SEND) ? '0 : (state == DRAIN && fall) ? nb_inc : nbytes;
      if (state == RUN && bus.exp_stop) begin
        bus.res_data <= bus.exp_ans;
        bus.last_cycles <= cyc_inc;
      end
      if (bus.load_valid && state != IDLE && bus.dropped != 8'hFF)
        bus.dropped <= bus.dropped + 8'd1;
      bus.rx_enable <= nxt == IDLE;
      bus.exp_start <= nxt == START;
      bus.res_valid <= nxt == SEND;
      bus.busy <= nxt != IDLE;
      bus.err <= nxt == ERR;
    end
  end
endmodule

// File: tb/tb_rsa_job_ctrl.sv
// tb_rsa_job_ctrl: scoreboard bench for the RSA job sequencer
module tb_rsa_job_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  logic [63:0] q_ans[$];
  logic [23:0] q_cyc[$];
  rsa_job_if #(.BITLEN(64), .CNTW(24)) bus ();
  rsa_job_ctrl #(.BITLEN(64), .CNTW(24), .TIMEOUT(24'd100)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // scoreboard: every result pulse must match the oldest job issued
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.exp_start) n_start++;
      if (bus.res_valid) begin
        if (q_ans.size() == 0) chk("unexpected_res_valid", 1, 0);
        else begin
          chk("res_data", bus.res_data, q_ans.pop_front());
          chk("last_cycles", 64'(bus.last_cycles), 64'(q_cyc.pop_front()));
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_job;
    tick();
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
  endtask
  task automatic run_job(input logic [63:0] ans, input int ncyc, input int d_run);
    start_job();
    chk("exp_start", bus.exp_start, 1);
    chk("busy_at_start", bus.busy, 1);
    chk("rx_enable_at_start", bus.rx_enable, 0);
    q_ans.push_back(ans);
    q_cyc.push_back(24'(ncyc));
    for (int i = 0; i < ncyc; i++) begin
      bus.load_valid = i[0] && i < 2 * d_run;
      tick();
    end
    bus.load_valid = 1'b0;
    bus.exp_stop = 1'b1;
    bus.exp_ans = ans;
    tick();
    bus.exp_stop = 1'b0;
    bus.exp_ans = $urandom();
  endtask
  task automatic send_bytes(input int n, input int d_drain, input bit last);
    for (int b = 0; b < n; b++) begin
      bus.tx_busy = 1'b1;
      bus.load_valid = b >= 1 && b <= d_drain;
      tick();
      bus.load_valid = 1'b0;
      tick();
      bus.tx_busy = 1'b0;
      if (last && b == n - 1) chk("busy_before_last_fall", bus.busy, 1);
      tick();
    end
    if (last) begin
      chk("busy_after_drain", bus.busy, 0);
      chk("rx_enable_after_drain", bus.rx_enable, 1);
    end
  endtask
  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rx_enable"}, bus.rx_enable, 1);
    chk({pfx, "_exp_start"}, bus.exp_start, 0);
    chk({pfx, "_res_valid"}, bus.res_valid, 0);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_err"}, bus.err, 0);
    chk({pfx, "_res_data"}, bus.res_data, 0);
    chk({pfx, "_dropped"}, 64'(bus.dropped), 0);
    chk({pfx, "_last_cycles"}, 64'(bus.last_cycles), 0);
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.exp_stop = 1'b0;
    bus.exp_ans = '0;
    bus.tx_busy = 1'b0;
    bus.clr_err = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (6) tick();
    // nominal job with 3 drops in RUN and 2 in DRAIN
    run_job(64'h0123456789ABCDEF, 50, 3);
    chk("res_valid_pulse", bus.res_valid, 1);
    send_bytes(8, 2, 1'b1);
    chk("dropped_5", 64'(bus.dropped), 5);
    chk("one_start", 64'(n_start), 1);
    // spurious inputs in IDLE
    bus.exp_stop = 1'b1;
    bus.exp_ans = 64'hBADBADBADBADBAD0;
    bus.clr_err = 1'b1;
    tick();
    bus.exp_stop = 1'b0;
    bus.clr_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.tx_busy = i[0];
      tick();
    end
    bus.tx_busy = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_rx_enable", bus.rx_enable, 1);
    chk("idle_err", bus.err, 0);
    chk("idle_res_data", bus.res_data, 64'h0123456789ABCDEF);
    chk("idle_last_cycles", 64'(bus.last_cycles), 50);
    chk("idle_no_start", 64'(n_start), 1);
    // watchdog: no stop, ERR after 100 RUN cycles
    start_job();
    repeat (100) tick();
    chk("wd_err_before", bus.err, 0);
    chk("wd_busy_before", bus.busy, 1);
    tick();
    chk("wd_err", bus.err, 1);
    chk("wd_busy", bus.busy, 1);
    bus.exp_stop = 1'b1;
    bus.exp_ans = 64'hFEEDFACECAFEBEEF;
    tick();
    bus.exp_stop = 1'b0;
    tick();
    chk("wd_late_stop_res", bus.res_data, 64'h0123456789ABCDEF);
    chk("wd_err_held", bus.err, 1);
    for (int i = 0; i < 300; i++) begin
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
      tick();
    end
    chk("dropped_saturate", 64'(bus.dropped), 255);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("clr_err_err", bus.err, 0);
    chk("clr_err_busy", bus.busy, 0);
    chk("clr_err_rx_enable", bus.rx_enable, 1);
    tick();
    // race: stop in the 100th RUN cycle, where the watchdog also expires
    run_job(64'h5555AAAA3333CCCC, 100, 0);
    chk("race_res_valid", bus.res_valid, 1);
    chk("race_err", bus.err, 0);
    repeat (3) tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("race_recover_busy", bus.busy, 0);
    tick();
    // reset in the middle of DRAIN
    run_job(64'h1122334455667788, 20, 0);
    send_bytes(3, 0, 1'b0);
    chk("mid_drain_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    chk_reset_vals("mid_drain_rst");
    rst = 1'b0;
    bus.exp_stop = 1'b1;
    bus.exp_ans = 64'hDEADDEADDEADDEAD;
    tick();
    bus.exp_stop = 1'b0;
    tick();
    chk("post_rst_stop_ignored", bus.res_data, 0);
    run_job(64'h8877665544332211, 40, 0);
    send_bytes(8, 0, 1'b1);
    chk("post_rst_dropped", 64'(bus.dropped), 0);
    chk("post_rst_res", bus.res_data, 64'h8877665544332211);
    repeat (2) tick();
    chk("total_starts", 64'(n_start), 5);
    chk("queue_empty", 64'(q_ans.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
